// File: rtl/pacote_bcd.sv
// Shared types and constants for the BCD display scheduler.
// Latency: n/a (declarations only). Backpressure: n/a.
package pacote_bcd;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONVERTE = 2'd1,
        FIM      = 2'd2
    } estado_t;

    localparam int          N_DIGITOS  = 4;
    localparam logic [31:0] LIMITE     = 32'd9999;
    localparam logic [3:0]  DIGITO_MAX = 4'd9;

    function automatic logic [3:0] ajusta(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/passo_bcd.sv
// One shift/add-3 step of the binary-to-BCD core.
// Latency: combinational. Backpressure: none, the caller registers the result.
module passo_bcd
    import pacote_bcd::*;
(
    input  logic [4*N_DIGITOS-1:0] bcd,
    input  logic                   bit_novo,
    output logic [4*N_DIGITOS-1:0] proximo
);

    logic [4*N_DIGITOS-1:0] ajustado;

    always_comb begin
        ajustado = '0;
        for (int i = 0; i < N_DIGITOS; i++) begin
            ajustado[4*i +: 4] = ajusta(bcd[4*i +: 4]);
        end
        // Carry out of the top digit is dropped by the truncating cast.
        proximo = (4*N_DIGITOS)'({ajustado, bit_novo});
    end

endmodule

// File: rtl/escalonador_bcd.sv
// Round-robin scheduler sharing one iterative binary-to-BCD core between two requesters.
// Latency: ack 1 cycle after capture, done 18 cycles after capture.
// Backpressure: requests are only sampled in OCIOSO; req must be held until ack.
module escalonador_bcd #(
    parameter int          N_BITS = 16,
    parameter logic [31:0] LIMITE = 32'd9999
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [31:0] numero0,
    input  logic [31:0] numero1,
    output logic [1:0]  ack,
    output logic        busy,
    output logic        done,
    output logic        origem,
    output logic        sinal,
    output logic        overflow,
    output logic [3:0]  milhar,
    output logic [3:0]  centena,
    output logic [3:0]  dezena,
    output logic [3:0]  unidade
);
    import pacote_bcd::*;

    localparam int            CW     = $clog2(N_BITS);
    localparam int            WB     = 4 * N_DIGITOS;
    localparam logic [CW-1:0] ULTIMO = CW'(N_BITS - 1);

    estado_t           estado, proximo_estado;
    logic              ponteiro;
    logic [N_BITS-1:0] mag;
    logic [WB-1:0]     acc, acc_prox;
    logic [CW-1:0]     cont;
    logic              sinal_pend, origem_pend, ovf_pend;

    logic              tem_pedido, concedido;
    logic [31:0]       operando, magnitude;

    passo_bcd u_passo (
        .bcd      (acc),
        .bit_novo (mag[N_BITS-1]),
        .proximo  (acc_prox)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) estado <= OCIOSO;
        else        estado <= proximo_estado;
    end

    always_comb begin
        proximo_estado = estado;
        case (estado)
            OCIOSO:   if (tem_pedido)     proximo_estado = CONVERTE;
            CONVERTE: if (cont == ULTIMO) proximo_estado = FIM;
            FIM:                          proximo_estado = OCIOSO;
            default:                      proximo_estado = OCIOSO;
        endcase
    end

    // On a tie the requester other than the pointer wins.
    always_comb begin
        tem_pedido = |req;
        concedido  = (req == 2'b11) ? ~ponteiro : req[1];
        operando   = concedido ? numero1 : numero0;
        magnitude  = operando[31] ? (~operando + 32'd1) : operando;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ponteiro    <= 1'b1;
            mag         <= '0;
            acc         <= '0;
            cont        <= '0;
            sinal_pend  <= 1'b0;
            origem_pend <= 1'b0;
            ovf_pend    <= 1'b0;
            ack         <= 2'b00;
            busy        <= 1'b0;
            done        <= 1'b0;
            origem      <= 1'b0;
            sinal       <= 1'b0;
            overflow    <= 1'b0;
            {milhar, centena, dezena, unidade} <= '0;
        end else begin
            ack  <= 2'b00;
            done <= 1'b0;
            case (estado)
                OCIOSO: begin
                    busy <= tem_pedido;
                    if (tem_pedido) begin
                        ack         <= concedido ? 2'b10 : 2'b01;
                        origem_pend <= concedido;
                        sinal_pend  <= operando[31];
                        ovf_pend    <= (magnitude > LIMITE);
                        mag         <= magnitude[N_BITS-1:0];
                        acc         <= '0;
                        cont        <= '0;
                        if (req == 2'b11) ponteiro <= concedido;
                    end
                end
                CONVERTE: begin
                    acc  <= acc_prox;
                    mag  <= {mag[N_BITS-2:0], 1'b0};
                    cont <= cont + 1'b1;
                end
                FIM: begin
                    done     <= 1'b1;
                    origem   <= origem_pend;
                    sinal    <= sinal_pend;
                    overflow <= ovf_pend;
                    {milhar, centena, dezena, unidade} <=
                        ovf_pend ? {N_DIGITOS{DIGITO_MAX}} : acc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_escalonador_bcd.sv
// Directed bench for escalonador_bcd: arbitration, latency, BCD results, reset mid-conversion.
module tb_escalonador_bcd;

    logic        clock   = 1'b0;
    logic        reset   = 1'b0;
    logic [1:0]  req     = 2'b00;
    logic [31:0] numero0 = '0;
    logic [31:0] numero1 = '0;
    logic [1:0]  ack;
    logic        busy, done, origem, sinal, overflow;
    logic [3:0]  milhar, centena, dezena, unidade;

    int testes = 0;
    int falhas = 0;

    always #5 clock = ~clock;

    escalonador_bcd dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .numero0  (numero0),
        .numero1  (numero1),
        .ack      (ack),
        .busy     (busy),
        .done     (done),
        .origem   (origem),
        .sinal    (sinal),
        .overflow (overflow),
        .milhar   (milhar),
        .centena  (centena),
        .dezena   (dezena),
        .unidade  (unidade)
    );

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        testes++;
        if (obs !== esp) begin
            falhas++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
        end
    endtask

    task automatic ciclo();
        @(posedge clock);
        #1;
    endtask

    task automatic confere(input string tag, input logic o, input logic s, input logic v,
                           input logic [15:0] dig);
        verifica({tag, "_origem"},   32'(origem),   32'(o));
        verifica({tag, "_sinal"},    32'(sinal),    32'(s));
        verifica({tag, "_overflow"}, 32'(overflow), 32'(v));
        verifica({tag, "_digitos"},  32'({milhar, centena, dezena, unidade}), 32'(dig));
    endtask

    // Waits for the grant, checks it, then follows the conversion up to one cycle past done.
    task automatic servico(input string tag, input logic [1:0] ack_esp, input bit larga,
                           input bit pulso);
        int t;
        int n;
        int acks;
        t = 0;
        while (ack == 2'b00 && t < 40) begin
            ciclo();
            t++;
        end
        verifica({tag, "_ack"}, 32'(ack), 32'(ack_esp));
        if (larga) req = req & ~ack_esp;
        n = 0;
        acks = 0;
        do begin
            ciclo();
            n++;
            if (ack != 2'b00) acks++;
            if (pulso && n == 3) begin
                req = req | 2'b10;
                #3;
                req = req & 2'b01;
            end
        end while (!done && n < 40);
        verifica({tag, "_latencia"}, 32'(n), 32'd17);
        verifica({tag, "_ack_extra"}, 32'(acks), 32'd0);
        verifica({tag, "_busy_done"}, 32'(busy), 32'd1);
        ciclo();
        verifica({tag, "_done_pulso"}, 32'(done), 32'd0);
    endtask

    initial begin
        int t;
        int n;

        #2;
        verifica("rst_ack",  32'(ack),  32'd0);
        verifica("rst_busy", 32'(busy), 32'd0);
        verifica("rst_done", 32'(done), 32'd0);
        confere("rst", 1'b0, 1'b0, 1'b0, 16'h0000);
        #10;
        reset = 1'b1;
        ciclo();

        // First tie after reset goes to requester 0.
        numero0 = 32'd1;
        numero1 = 32'd2;
        req     = 2'b11;
        servico("empate_a0", 2'b01, 1'b1, 1'b0);
        confere("empate_a0", 1'b0, 1'b0, 1'b0, 16'h0001);
        servico("empate_a1", 2'b10, 1'b1, 1'b0);
        confere("empate_a1", 1'b1, 1'b0, 1'b0, 16'h0002);

        numero0 = 32'd1234;
        req     = 2'b01;
        servico("n1234", 2'b01, 1'b1, 1'b0);
        confere("n1234", 1'b0, 1'b0, 1'b0, 16'h1234);

        numero1 = 32'hFFFF_FE05;
        req     = 2'b10;
        servico("m507", 2'b10, 1'b1, 1'b0);
        confere("m507", 1'b1, 1'b1, 1'b0, 16'h0507);

        // Pointer was left at 0 by the earlier tie, so requester 1 wins now.
        numero0 = 32'd9999;
        numero1 = 32'd42;
        req     = 2'b11;
        servico("empate_b1", 2'b10, 1'b1, 1'b0);
        confere("empate_b1", 1'b1, 1'b0, 1'b0, 16'h0042);
        servico("empate_b0", 2'b01, 1'b1, 1'b0);
        confere("empate_b0", 1'b0, 1'b0, 1'b0, 16'h9999);

        numero0 = 32'd10000;
        req     = 2'b01;
        servico("n10000", 2'b01, 1'b1, 1'b0);
        confere("n10000", 1'b0, 1'b0, 1'b1, 16'h9999);

        numero0 = 32'h8000_0000;
        req     = 2'b01;
        servico("nmin", 2'b01, 1'b1, 1'b0);
        confere("nmin", 1'b0, 1'b1, 1'b1, 16'h9999);

        // Asynchronous reset in the 8th CONVERTE cycle.
        numero0 = 32'd5;
        req     = 2'b01;
        t = 0;
        while (ack == 2'b00 && t < 40) begin
            ciclo();
            t++;
        end
        verifica("rst_meio_ack", 32'(ack), 32'h1);
        req = 2'b00;
        repeat (7) ciclo();
        #2;
        reset = 1'b0;
        #1;
        verifica("rst_meio_ack0",  32'(ack),  32'd0);
        verifica("rst_meio_busy",  32'(busy), 32'd0);
        verifica("rst_meio_done",  32'(done), 32'd0);
        confere("rst_meio", 1'b0, 1'b0, 1'b0, 16'h0000);
        #2;
        reset = 1'b1;
        n = 0;
        repeat (30) begin
            ciclo();
            if (done) n++;
        end
        verifica("rst_meio_sem_done", 32'(n), 32'd0);
        verifica("rst_meio_ocioso", 32'(busy), 32'd0);

        numero0 = 32'd0;
        req     = 2'b01;
        servico("zero", 2'b01, 1'b1, 1'b0);
        confere("zero", 1'b0, 1'b0, 1'b0, 16'h0000);

        // Held request plus an unsampled glitch on req[1] during conversion.
        numero0 = 32'd77;
        req     = 2'b01;
        servico("retido", 2'b01, 1'b0, 1'b1);
        verifica("retido_reatendido", 32'(ack), 32'h1);
        confere("retido", 1'b0, 1'b0, 1'b0, 16'h0077);
        req = 2'b00;
        servico("retido2", 2'b01, 1'b1, 1'b0);
        confere("retido2", 1'b0, 1'b0, 1'b0, 16'h0077);

        $display("[TB] %0d tests run, %0d failed", testes, falhas);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

endmodule
